// File: rtl/bus_pkg.sv
// Shared types and default region geometry for the bus decoder.
package bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam int MAX_REG     = 8;
  localparam int MAX_ADDR_W  = 64;
  localparam int TBL_W       = MAX_REG * MAX_ADDR_W;
  localparam int REGION_SPAN = 256;

  // Builds the default packed region table: region i covers
  // [REGION_SPAN*i, REGION_SPAN*(i+1)). With limit=1 the upper bounds are
  // returned, otherwise the bases. Callers truncate to N_REG*ADDR_W bits.
  function automatic logic [TBL_W-1:0] default_table(input int n_reg,
                                                     input int addr_w,
                                                     input bit limit);
    logic [TBL_W-1:0] tbl;
    tbl = '0;
    for (int i = 0; i < MAX_REG; i++) begin
      if (i < n_reg) begin
        tbl = tbl | (TBL_W'(REGION_SPAN * (i + int'(limit))) << (i * addr_w));
      end
    end
    return tbl;
  endfunction

endpackage

// File: rtl/addr_match.sv
// Combinational region lookup: finds the lowest-index region containing
// addr and reports its index and the offset from that region's base.
module addr_match #(
  parameter int N_REG  = 4,
  parameter int ADDR_W = 32,
  parameter int IDX_W  = 2
) (
  input  logic [ADDR_W-1:0]       addr,
  input  logic [N_REG*ADDR_W-1:0] base,
  input  logic [N_REG*ADDR_W-1:0] limit,
  output logic                    hit,
  output logic [IDX_W-1:0]        idx,
  output logic [ADDR_W-1:0]       offset
);

  logic [ADDR_W-1:0] b;
  logic [ADDR_W-1:0] l;

  // Scan from the highest index down so the lowest matching region wins.
  always_comb begin
    hit    = 1'b0;
    idx    = '0;
    offset = '0;
    b      = '0;
    l      = '0;
    for (int i = N_REG - 1; i >= 0; i--) begin
      b = base[i*ADDR_W +: ADDR_W];
      l = limit[i*ADDR_W +: ADDR_W];
      // An empty or inverted region (base >= limit) can never match.
      if ((b < l) && (addr >= b) && (addr < l)) begin
        hit    = 1'b1;
        idx    = IDX_W'(i);
        offset = addr - b;
      end
    end
  end

endmodule

// File: rtl/bus_decoder.sv
// Single-outstanding bus decoder: routes one request to a matching slave
// region, waits for its ack with a bounded timeout, and returns a response.
//
// state  | meaning
// IDLE   | ready for a request; decode on accept
// ACCESS | slave selected, waiting for ack or timeout
// RESP   | rsp_valid high for one cycle
module bus_decoder
  import bus_pkg::*;
#(
  parameter int N_REG   = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15,
  parameter logic [N_REG*ADDR_W-1:0] REG_BASE  =
    (N_REG*ADDR_W)'(default_table(N_REG, ADDR_W, 1'b0)),
  parameter logic [N_REG*ADDR_W-1:0] REG_LIMIT =
    (N_REG*ADDR_W)'(default_table(N_REG, ADDR_W, 1'b1))
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_wr,
  input  logic [ADDR_W-1:0]       req_addr,
  input  logic [DATA_W-1:0]       req_wdata,
  output logic                    rsp_valid,
  output logic [DATA_W-1:0]       rsp_rdata,
  output logic                    rsp_err,
  output logic [N_REG-1:0]        sel,
  output logic [N_REG-1:0]        wr_en,
  output logic [ADDR_W-1:0]       s_addr,
  output logic [DATA_W-1:0]       s_wdata,
  input  logic [N_REG*DATA_W-1:0] s_rdata,
  input  logic [N_REG-1:0]        s_ack
);

  localparam int IDX_W = (N_REG > 1) ? $clog2(N_REG) : 1;
  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

  state_t              state_q, state_d;
  logic                hit;
  logic [IDX_W-1:0]    idx;
  logic [ADDR_W-1:0]   offset;
  logic [IDX_W-1:0]    idx_q;
  logic                wr_q;
  logic [7:0]          wait_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                err_q;
  logic                accept;
  logic                ack_sel;
  logic                timed_out;
  logic [DATA_W-1:0]   rdata_sel;

  addr_match #(
    .N_REG  (N_REG),
    .ADDR_W (ADDR_W),
    .IDX_W  (IDX_W)
  ) u_match (
    .addr   (req_addr),
    .base   (REG_BASE),
    .limit  (REG_LIMIT),
    .hit    (hit),
    .idx    (idx),
    .offset (offset)
  );

  assign req_ready = (state_q == IDLE);
  assign accept    = req_valid & req_ready;
  assign ack_sel   = s_ack[idx_q];
  assign rdata_sel = s_rdata[idx_q*DATA_W +: DATA_W];
  // wait_q holds the number of completed ACCESS cycles, so the current
  // cycle is the last allowed one when it equals TIMEOUT-1.
  assign timed_out = (wait_q == LAST_WAIT);

  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rsp_valid ? rdata_q : '0;
  assign rsp_err   = rsp_valid & err_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state decode; ack takes priority over the timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = hit ? ACCESS : RESP;
      ACCESS:  if (ack_sel || timed_out) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Transaction capture, wait counter and response data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q   <= '0;
      wr_q    <= 1'b0;
      s_addr  <= '0;
      s_wdata <= '0;
      wait_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        idx_q   <= idx;
        wr_q    <= req_wr;
        s_addr  <= offset;
        s_wdata <= req_wdata;
        wait_q  <= '0;
        if (!hit) begin
          rdata_q <= '0;
          err_q   <= 1'b1;
        end
      end else if (state_q == ACCESS) begin
        wait_q <= wait_q + 8'd1;
        if (ack_sel) begin
          rdata_q <= wr_q ? '0 : rdata_sel;
          err_q   <= 1'b0;
        end else if (timed_out) begin
          rdata_q <= '0;
          err_q   <= 1'b1;
        end
      end
    end
  end

  // Slave strobes: select held through ACCESS, write enable on its first cycle.
  always_comb begin
    sel   = '0;
    wr_en = '0;
    if (state_q == ACCESS) begin
      sel[idx_q]   = 1'b1;
      wr_en[idx_q] = wr_q & (wait_q == 8'd0);
    end
  end

endmodule

// File: tb/tb_bus_decoder.sv
// Directed testbench for bus_decoder: default map plus an overlapping map.
module tb_bus_decoder;

  logic         clk;
  logic         rst_n;
  logic         req_valid;
  logic         req_wr;
  logic [31:0]  req_addr;
  logic [31:0]  req_wdata;
  logic [127:0] s_rdata;
  logic [3:0]   s_ack;

  logic         req_ready, rsp_valid, rsp_err;
  logic [31:0]  rsp_rdata, s_addr, s_wdata;
  logic [3:0]   sel, wr_en;

  logic         req_ready_o, rsp_valid_o, rsp_err_o;
  logic [31:0]  rsp_rdata_o, s_addr_o, s_wdata_o;
  logic [3:0]   sel_o, wr_en_o;

  int checks = 0;
  int errors = 0;

  bus_decoder dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .sel(sel), .wr_en(wr_en), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_rdata(s_rdata), .s_ack(s_ack)
  );

  // Region 0 widened to [0,0x200) so it overlaps region 1; its slaves ack at once.
  bus_decoder #(
    .REG_LIMIT({32'h400, 32'h300, 32'h200, 32'h200})
  ) dut_ovl (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready_o), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid_o), .rsp_rdata(rsp_rdata_o), .rsp_err(rsp_err_o),
    .sel(sel_o), .wr_en(wr_en_o), .s_addr(s_addr_o), .s_wdata(s_wdata_o),
    .s_rdata(s_rdata), .s_ack(sel_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one request for a single edge; returns in the first cycle after accept.
  task automatic issue(input logic [31:0] addr, input logic wr, input logic [31:0] wdata);
    chk("ready_before_issue", req_ready, 1'b1);
    req_valid = 1'b1;
    req_addr  = addr;
    req_wr    = wr;
    req_wdata = wdata;
    step();
    req_valid = 1'b0;
  endtask

  initial begin
    int  n;
    bit  got;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_wr    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    s_ack     = '0;
    s_rdata   = {32'h3333, 32'hBEEF, 32'hCAFE, 32'h1111};

    #12;
    chk("rst_ready", req_ready, 1'b1);
    chk("rst_valid", rsp_valid, 1'b0);
    chk("rst_err", rsp_err, 1'b0);
    chk("rst_rdata", rsp_rdata, 32'h0);
    chk("rst_sel", sel, 4'b0000);
    chk("rst_wr_en", wr_en, 4'b0000);
    chk("rst_s_addr", s_addr, 32'h0);
    chk("rst_s_wdata", s_wdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Read 0x104, slave 1 acks on the first ACCESS cycle.
    issue(32'h104, 1'b0, 32'h0);
    chk("rd_sel", sel, 4'b0010);
    chk("rd_ready_busy", req_ready, 1'b0);
    chk("rd_s_addr", s_addr, 32'h4);
    chk("rd_no_early_valid", rsp_valid, 1'b0);
    s_ack = 4'b0010;
    step();
    s_ack = 4'b0000;
    chk("rd_valid", rsp_valid, 1'b1);
    chk("rd_rdata", rsp_rdata, 32'hCAFE);
    chk("rd_err", rsp_err, 1'b0);
    chk("rd_sel_off", sel, 4'b0000);
    step();
    chk("rd_valid_one_cycle", rsp_valid, 1'b0);
    chk("rd_rdata_idle", rsp_rdata, 32'h0);

    // Write 0x0FF, ack on the second ACCESS cycle.
    issue(32'h0FF, 1'b1, 32'h55);
    chk("wr_sel", sel, 4'b0001);
    chk("wr_en_first", wr_en, 4'b0001);
    chk("wr_s_addr", s_addr, 32'hFF);
    chk("wr_s_wdata", s_wdata, 32'h55);
    step();
    chk("wr_sel_hold", sel, 4'b0001);
    chk("wr_en_second", wr_en, 4'b0000);
    s_ack = 4'b0001;
    step();
    s_ack = 4'b0000;
    chk("wr_valid", rsp_valid, 1'b1);
    chk("wr_err", rsp_err, 1'b0);
    chk("wr_rdata", rsp_rdata, 32'h0);
    chk("wr_s_wdata_hold", s_wdata, 32'h55);
    step();

    // Unmapped read.
    issue(32'h1000, 1'b0, 32'h0);
    chk("um_valid", rsp_valid, 1'b1);
    chk("um_err", rsp_err, 1'b1);
    chk("um_rdata", rsp_rdata, 32'h0);
    chk("um_sel", sel, 4'b0000);
    step();
    chk("um_idle", req_ready, 1'b1);

    // Read 0x200, no ack from slave 2 while all other slaves ack.
    issue(32'h200, 1'b0, 32'h0);
    s_ack = 4'b1011;
    n = 0;
    got = 0;
    for (int k = 0; k < 40 && !got; k++) begin
      if (rsp_valid) got = 1;
      else begin
        if (sel == 4'b0100) n++;
        step();
      end
    end
    s_ack = 4'b0000;
    chk("to_valid_seen", got, 1'b1);
    chk("to_sel_cycles", n, 15);
    chk("to_err", rsp_err, 1'b1);
    chk("to_rdata", rsp_rdata, 32'h0);
    step();

    // Read 0x200, ack arrives on the 15th ACCESS cycle.
    issue(32'h200, 1'b0, 32'h0);
    for (int k = 0; k < 14; k++) step();
    chk("ack15_sel", sel, 4'b0100);
    chk("ack15_not_done", rsp_valid, 1'b0);
    s_ack = 4'b0100;
    step();
    s_ack = 4'b0000;
    chk("ack15_valid", rsp_valid, 1'b1);
    chk("ack15_err", rsp_err, 1'b0);
    chk("ack15_rdata", rsp_rdata, 32'hBEEF);
    step();

    // Overlapping map: 0x150 lands in region 0 there, region 1 in the default map.
    issue(32'h150, 1'b0, 32'h0);
    chk("ovl_sel", sel_o, 4'b0001);
    chk("ovl_s_addr", s_addr_o, 32'h150);
    chk("def_sel", sel, 4'b0010);
    s_ack = 4'b0010;
    step();
    s_ack = 4'b0000;
    chk("ovl_valid", rsp_valid_o, 1'b1);
    chk("ovl_rdata", rsp_rdata_o, 32'h1111);
    chk("def_rdata", rsp_rdata, 32'hCAFE);
    step();

    // Reset in the middle of an ACCESS.
    issue(32'h300, 1'b0, 32'h0);
    step();
    chk("mid_sel_pre", sel, 4'b1000);
    rst_n = 1'b0;
    #1;
    chk("mid_sel", sel, 4'b0000);
    chk("mid_ready", req_ready, 1'b1);
    chk("mid_valid", rsp_valid, 1'b0);
    chk("mid_s_addr", s_addr, 32'h0);
    step();
    chk("mid_valid_held", rsp_valid, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("post_rst_valid", rsp_valid, 1'b0);
    issue(32'h104, 1'b0, 32'h0);
    chk("post_rst_sel", sel, 4'b0010);
    s_ack = 4'b0010;
    step();
    s_ack = 4'b0000;
    chk("post_rst_rsp", rsp_valid, 1'b1);
    chk("post_rst_rdata", rsp_rdata, 32'hCAFE);
    chk("post_rst_err", rsp_err, 1'b0);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_decoder.md
BUS_DECODER -- requirements
Module: bus_decoder

Interface
REQ-001 SHALL have parameter N_REG, default 4, meaning number of decoded address regions (1..8).
REQ-002 SHALL have parameter ADDR_W, default 32, meaning request address width.
REQ-003 SHALL have parameter DATA_W, default 32, meaning data width.
REQ-004 SHALL have parameter TIMEOUT, default 15, meaning maximum ACCESS cycles waiting for slave_ack (1..255).
REQ-005 SHALL have parameters REG_BASE and REG_LIMIT, each N_REG x ADDR_W packed; defaults are region i = [256*i, 256*(i+1)).
REQ-006 SHALL have ports: clk  in  1  clock; rst_n  in  1  asynchronous active-low reset.
REQ-007 SHALL have ports: req_valid in 1; req_ready out 1; req_wr in 1 (1=write); req_addr in ADDR_W; req_wdata in DATA_W.
REQ-008 SHALL have ports: rsp_valid out 1; rsp_rdata out DATA_W; rsp_err out 1 (unmapped or timeout).
REQ-009 SHALL have ports: sel out N_REG (one-hot slave select); wr_en out N_REG; s_addr out ADDR_W (offset = addr - base); s_wdata out DATA_W.
REQ-010 SHALL have ports: s_rdata in N_REG*DATA_W (slave i at bits [i*DATA_W +: DATA_W]); s_ack in N_REG.

Function
REQ-011 SHALL implement FSM states IDLE, ACCESS, RESP.
REQ-012 SHALL drive req_ready=1 only in IDLE; accept a request when req_valid & req_ready on a rising clk edge.
REQ-013 On accept, SHALL register req_wr, req_wdata, the matched region index and s_addr.
REQ-014 Region i SHALL match when REG_BASE[i] <= addr < REG_LIMIT[i], unsigned; a region with BASE >= LIMIT never matches.
REQ-015 On overlapping matches, the lowest index SHALL win.
REQ-016 On a match, SHALL go IDLE->ACCESS; with no match, SHALL go IDLE->RESP with rsp_err=1 and rsp_rdata=0.
REQ-017 In ACCESS, SHALL hold sel[idx]=1 every cycle; wr_en[idx]=1 only on the first ACCESS cycle and only for writes. All other sel/wr_en bits SHALL be 0.
REQ-018 In ACCESS, SHALL sample s_ack[idx]; on ack, SHALL capture rdata (reads) or 0 (writes), set rsp_err=0 and go to RESP. s_ack of unselected slaves SHALL be ignored.
REQ-019 SHALL count ACCESS cycles in an 8-bit wait counter cleared on accept; with no ack after TIMEOUT cycles, SHALL go to RESP with rsp_err=1 and rsp_rdata=0.
REQ-020 If ack arrives in the same cycle the counter reaches TIMEOUT, ack SHALL take priority (no error).
REQ-021 In RESP, SHALL assert rsp_valid for exactly one cycle, then return to IDLE; rsp_rdata/rsp_err SHALL be valid only while rsp_valid=1.
REQ-022 Latency from accept edge: unmapped -> rsp_valid in the next cycle; ack on the first ACCESS cycle -> rsp_valid two cycles after accept.
REQ-023 Outside ACCESS, sel and wr_en SHALL be 0 and s_addr/s_wdata SHALL hold their last registered values.
REQ-024 Back-to-back traffic SHALL be accepted only after RESP (max one transaction in flight).

Reset
REQ-025 rst_n low SHALL asynchronously force IDLE; req_ready=1, rsp_valid=0, rsp_err=0, rsp_rdata=0, sel=0, wr_en=0, s_addr=0, s_wdata=0, counter=0.
REQ-026 Reset mid-ACCESS SHALL drop the transaction with no rsp_valid; the first request after release SHALL decode normally.

Structure
REQ-027 State enum (IDLE, ACCESS, RESP) and default region table constants SHALL live in shared package bus_pkg.
REQ-028 Region matching and priority SHALL be a combinational sub-module addr_match (inputs: addr, tables; outputs: hit, idx, offset).

Verification
REQ-029 Read 0x104, slave1 acks on the first ACCESS cycle with 0xCAFE -> sel=0010, rsp_valid two cycles after accept, rdata=0xCAFE, err=0.
REQ-030 Write 0x0FF data 0x55 -> wr_en[0] high exactly one cycle, s_addr=0xFF, s_wdata=0x55, rsp err=0.
REQ-031 Read 0x1000 (unmapped) -> no sel, rsp_valid next cycle, err=1, rdata=0.
REQ-032 Read 0x200, no ack -> sel[2] high 15 cycles, then rsp err=1; ack on cycle 15 instead -> err=0.
REQ-033 Overlapping table (region0 [0,0x200)), addr 0x150 -> sel[0].
REQ-034 rst_n low during ACCESS -> outputs at reset values immediately with no rsp_valid; next request completes normally.
